// File: rtl/sync_edge.sv
// sync_edge
//   Two-flop synchronizer for an asynchronous input, followed by a delayed copy
//   used for rising-edge detection. Shared by the input monitors.
//
//   clk_i   in   system clock (rising edge)
//   rst_i   in   synchronous, active-high reset; all flops clear to 0
//   d_i     in   asynchronous input
//   q_o     out  synchronized input (second synchronizer stage)
//   rise_o  out  one-cycle pulse while q_o is high and its delayed copy is low
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = d_i;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/pwm_meter.sv
// pwm_meter
//   Measures period and high time (in clk_i cycles) of a slow free-running
//   input. One report per input cycle, strobed by valid_o. A stalled input
//   produces a single timeout report.
//
//   CNT_WIDTH    counter / output width; MAX = 2^CNT_WIDTH - 1
//   clk_i        in   system clock (rising edge)
//   rst_i        in   synchronous, active-high reset
//   sig_i        in   measured signal, asynchronous to clk_i
//   period_o     out  cycles between the last two rising edges; 0 on timeout
//   high_o       out  high cycles within that period; on timeout all-ones if
//                     stuck high, 0 if stuck low
//   valid_o      out  one-cycle strobe, outputs updated in the same cycle
//   timeout_o    out  high from a timeout report until the next normal report
module pwm_meter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sig_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 valid_o,
    output logic                 timeout_o
);

    localparam logic [0:0]           ST_ARM     = 1'b0;
    localparam logic [0:0]           ST_MEASURE = 1'b1;
    localparam logic [CNT_WIDTH-1:0] MAX        = '1;
    localparam logic [CNT_WIDTH-1:0] ONE        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic s2, rise;

    sync_edge u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (sig_i),
        .q_o    (s2),
        .rise_o (rise)
    );

    logic [0:0]           state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [CNT_WIDTH-1:0] hcnt_q,    hcnt_d;
    // Set once a timeout has been reported for the current stall, so the
    // held-at-MAX counter in ARM does not report again every cycle.
    logic                 to_done_q, to_done_d;
    logic [CNT_WIDTH-1:0] period_q,  period_d;
    logic [CNT_WIDTH-1:0] high_q,    high_d;
    logic                 valid_q,   valid_d;
    logic                 timeout_q, timeout_d;

    logic cnt_max;
    assign cnt_max = (cnt_q == MAX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        to_done_d = to_done_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            ST_ARM: begin
                if (rise) begin
                    // The partial cycle before the first edge is discarded.
                    cnt_d     = ONE;
                    hcnt_d    = ONE;
                    to_done_d = 1'b0;
                    state_d   = ST_MEASURE;
                end else if (!cnt_max) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!to_done_q) begin
                    period_d  = '0;
                    high_d    = {CNT_WIDTH{s2}};
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    to_done_d = 1'b1;
                end
            end
            ST_MEASURE: begin
                // A rise wins over timeout, so a period of exactly MAX is a
                // normal report.
                if (rise) begin
                    period_d  = cnt_q;
                    high_d    = hcnt_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    cnt_d     = ONE;
                    hcnt_d    = ONE;
                end else if (cnt_max) begin
                    period_d  = '0;
                    high_d    = {CNT_WIDTH{s2}};
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    to_done_d = 1'b1;
                    state_d   = ST_ARM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (s2 && (hcnt_q != MAX))
                        hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ARM;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            to_done_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            to_done_q <= to_done_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pwm_meter.sv
module tb_pwm_meter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         sig_i = 1'b0;
    logic [W-1:0] period_o;
    logic [W-1:0] high_o;
    logic         valid_o;
    logic         timeout_o;

    int n_assert = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int base;

    pwm_meter #(.CNT_WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .sig_i     (sig_i),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    // Strobe counter, sampled half a cycle after the active edge.
    always @(negedge clk)
        if (valid_o === 1'b1) vcnt <= vcnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply v for one clock edge, then settle just after the edge.
    task automatic step(input logic v);
        sig_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        run(1'b0, 2);
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset state
        run(1'b0, 3);
        chk("rst_valid",   {31'd0, valid_o},   0);
        chk("rst_period",  {24'd0, period_o},  0);
        chk("rst_high",    {24'd0, high_o},    0);
        chk("rst_timeout", {31'd0, timeout_o}, 0);
        rst_i = 1'b0;

        // Steady PWM 3 high / 5 low: arming period gives no report
        base = vcnt;
        for (int i = 0; i < 8; i++) step(i < 3);
        chk("pwm_no_first", vcnt - base, 0);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8; i++) begin
                step(i < 3);
                if (i == 2) begin
                    chk("pwm_valid",   {31'd0, valid_o},   1);
                    chk("pwm_period",  {24'd0, period_o},  8);
                    chk("pwm_high",    {24'd0, high_o},    3);
                    chk("pwm_timeout", {31'd0, timeout_o}, 0);
                end
                if (i == 3) chk("pwm_one_cycle", {31'd0, valid_o}, 0);
            end
        end
        chk("pwm_count", vcnt - base, 4);

        // Latency: arm, then rise before edge k
        do_reset();
        run(1'b1, 3);
        run(1'b0, 5);
        step(1'b1); chk("lat_k",    {31'd0, valid_o}, 0);
        step(1'b1); chk("lat_k1",   {31'd0, valid_o}, 0);
        step(1'b1); chk("lat_k2",   {31'd0, valid_o}, 1);
        chk("lat_period", {24'd0, period_o}, 8);
        step(1'b1); chk("lat_k3",   {31'd0, valid_o}, 0);

        // Timeout low
        do_reset();
        run(1'b1, 10);
        run(1'b0, 10);
        base = vcnt;
        run(1'b1, 3);
        chk("tol_rep_period", {24'd0, period_o}, 20);
        chk("tol_rep_high",   {24'd0, high_o},   10);
        run(1'b1, 7);
        run(1'b0, 247);
        chk("tol_early_valid", {31'd0, valid_o}, 0);
        chk("tol_early_count", vcnt - base, 1);
        step(1'b0);
        chk("tol_valid",   {31'd0, valid_o},   1);
        chk("tol_period",  {24'd0, period_o},  0);
        chk("tol_high",    {24'd0, high_o},    0);
        chk("tol_timeout", {31'd0, timeout_o}, 1);
        run(1'b0, 300);
        chk("tol_single",  vcnt - base, 2);
        chk("tol_hold_to", {31'd0, timeout_o}, 1);
        run(1'b1, 10);
        run(1'b0, 10);
        run(1'b1, 3);
        chk("tol_rec_valid",   {31'd0, valid_o},   1);
        chk("tol_rec_period",  {24'd0, period_o},  20);
        chk("tol_rec_high",    {24'd0, high_o},    10);
        chk("tol_rec_timeout", {31'd0, timeout_o}, 0);

        // Timeout high
        do_reset();
        run(1'b1, 10);
        run(1'b0, 10);
        base = vcnt;
        run(1'b1, 257);
        chk("toh_early_count", vcnt - base, 1);
        chk("toh_early_valid", {31'd0, valid_o}, 0);
        step(1'b1);
        chk("toh_valid",   {31'd0, valid_o},   1);
        chk("toh_period",  {24'd0, period_o},  0);
        chk("toh_high",    {24'd0, high_o},    255);
        chk("toh_timeout", {31'd0, timeout_o}, 1);

        // Boundary: period exactly MAX
        do_reset();
        run(1'b1, 100);
        run(1'b0, 155);
        run(1'b1, 2);
        chk("bnd_pre_valid", {31'd0, valid_o}, 0);
        step(1'b1);
        chk("bnd_valid",   {31'd0, valid_o},   1);
        chk("bnd_period",  {24'd0, period_o},  255);
        chk("bnd_high",    {24'd0, high_o},    100);
        chk("bnd_timeout", {31'd0, timeout_o}, 0);

        // Reset mid-measure
        do_reset();
        for (int i = 0; i < 16; i++) step(i % 8 < 3);
        run(1'b1, 3);
        step(1'b0);
        chk("rmm_pre_period", {24'd0, period_o}, 8);
        rst_i = 1'b1;
        step(1'b0);
        chk("rmm_valid",   {31'd0, valid_o},   0);
        chk("rmm_period",  {24'd0, period_o},  0);
        chk("rmm_high",    {24'd0, high_o},    0);
        chk("rmm_timeout", {31'd0, timeout_o}, 0);
        rst_i = 1'b0;
        run(1'b0, 3);
        base = vcnt;
        for (int i = 0; i < 8; i++) step(i < 3);
        chk("rmm_no_rep",    vcnt - base, 0);
        chk("rmm_no_period", {24'd0, period_o}, 0);
        for (int i = 0; i < 8; i++) step(i < 3);
        chk("rmm_rep_count",  vcnt - base, 1);
        chk("rmm_rep_period", {24'd0, period_o}, 8);
        chk("rmm_rep_high",   {24'd0, high_o},   3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
